// File: rtl/sio_chain_ctrl.sv
// Avalon-MM controller for a serial expander chain: generated SCLK, SLE framing,
// full-duplex shift of NWORDS x 32 bits with start/auto/done handshake and interrupt.
module sio_chain_ctrl #(
  parameter int          NWORDS  = 2,
  parameter int          CLKDIV  = 4,
  parameter logic [15:0] ID_CODE = 16'hEA69
) (
  input  logic        rsi_MRST_reset,
  input  logic        csi_MCLK_clk,
  input  logic [2:0]  avs_gpio_address,
  input  logic [31:0] avs_gpio_writedata,
  input  logic [3:0]  avs_gpio_byteenable,
  input  logic        avs_gpio_write,
  input  logic        avs_gpio_read,
  output logic [31:0] avs_gpio_readdata,
  output logic        avs_gpio_waitrequest,
  output logic        ins_irq_irq,
  output logic        EPL_SCLK,
  output logic        EPL_SDI,
  input  logic        EPL_SDO,
  output logic        EPL_SLE,
  input  logic        EPL_INT
);
  localparam int         N        = 32 * NWORDS;
  localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 1);
  localparam logic [7:0] BIT_LAST = 8'(N - 1);
  localparam logic [7:0] NW8      = 8'(NWORDS);
  localparam logic [7:0] CD8      = 8'(CLKDIV);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;
  state_t state, state_next;

  logic [7:0]   div_cnt;
  logic         div_wrap, rise_tick, fall_tick;
  logic [N-1:0] shreg, shreg_shifted, tx_flat;
  logic [7:0]   bitcnt;
  logic         sdo_s;
  logic [31:0]  tx_word [NWORDS];
  logic [31:0]  rx_word [NWORDS];
  logic         start_req, auto_en, done_ie, int_ie, done;
  logic         int_meta, int_sync;
  logic         ctrl_wr;
  logic         load_en, shift_en, latch_en, sle_next, sdi_next;
  logic [31:0]  rd_mux;

  assign avs_gpio_waitrequest = 1'b0;
  assign ins_irq_irq   = (done & done_ie) | (int_sync & int_ie);
  assign ctrl_wr       = avs_gpio_write && (avs_gpio_address == 3'd1);
  assign div_wrap      = (div_cnt == DIV_LAST);
  assign rise_tick     = div_wrap & ~EPL_SCLK;
  assign fall_tick     = div_wrap & EPL_SCLK;
  assign shreg_shifted = {shreg[N-2:0], sdo_s};

  always_comb begin
    tx_flat = '0;
    for (int k = 0; k < NWORDS; k++) tx_flat[N-1-32*k -: 32] = tx_word[k];
  end

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      div_cnt  <= '0;
      EPL_SCLK <= 1'b0;
    end else if (div_wrap) begin
      div_cnt  <= '0;
      EPL_SCLK <= ~EPL_SCLK;
    end else begin
      div_cnt  <= div_cnt + 8'd1;
    end
  end

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) state <= IDLE;
    else                state <= state_next;
  end

  // Every transition waits for a fall tick so SLE/SDI move with SCLK falling.
  always_comb begin
    state_next = state;
    load_en    = 1'b0;
    shift_en   = 1'b0;
    latch_en   = 1'b0;
    sle_next   = EPL_SLE;
    sdi_next   = EPL_SDI;
    case (state)
      IDLE: if (fall_tick && (start_req || auto_en)) begin
        state_next = LOAD;
        load_en    = 1'b1;
        sle_next   = 1'b0;
        sdi_next   = 1'b0;
      end
      LOAD: if (fall_tick) begin
        state_next = SHIFT;
        sle_next   = 1'b1;
        sdi_next   = shreg[N-1];
      end
      SHIFT: if (fall_tick) begin
        shift_en = 1'b1;
        if (bitcnt == BIT_LAST) begin
          state_next = LATCH;
          latch_en   = 1'b1;
          sle_next   = 1'b0;
          sdi_next   = 1'b0;
        end else begin
          sdi_next   = shreg[N-2];
        end
      end
      LATCH: if (fall_tick) begin
        if (auto_en) begin
          state_next = LOAD;
          load_en    = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      shreg   <= '0;
      bitcnt  <= '0;
      sdo_s   <= 1'b0;
      EPL_SLE <= 1'b0;
      EPL_SDI <= 1'b0;
      for (int k = 0; k < NWORDS; k++) rx_word[k] <= '0;
    end else begin
      EPL_SLE <= sle_next;
      EPL_SDI <= sdi_next;
      if (load_en) begin
        shreg  <= tx_flat;
        bitcnt <= '0;
      end else if (shift_en) begin
        shreg  <= shreg_shifted;
        bitcnt <= bitcnt + 8'd1;
      end
      if (state == SHIFT && rise_tick) sdo_s <= EPL_SDO;
      // The last sampled bit lands in RX directly so RX updates on LATCH entry.
      if (latch_en)
        for (int k = 0; k < NWORDS; k++) rx_word[k] <= shreg_shifted[N-1-32*k -: 32];
    end
  end

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      start_req <= 1'b0;
      auto_en   <= 1'b0;
      done_ie   <= 1'b0;
      int_ie    <= 1'b0;
      done      <= 1'b0;
      int_meta  <= 1'b0;
      int_sync  <= 1'b0;
      for (int k = 0; k < NWORDS; k++) tx_word[k] <= '0;
    end else begin
      int_meta <= EPL_INT;
      int_sync <= int_meta;
      if (ctrl_wr) begin
        auto_en <= avs_gpio_writedata[1];
        done_ie <= avs_gpio_writedata[2];
        int_ie  <= avs_gpio_writedata[3];
      end
      if (load_en)
        start_req <= 1'b0;
      else if (ctrl_wr && avs_gpio_writedata[0] && state == IDLE)
        start_req <= 1'b1;
      if (latch_en)
        done <= 1'b1;
      else if (ctrl_wr && avs_gpio_writedata[4])
        done <= 1'b0;
      for (int k = 0; k < NWORDS; k++)
        if (avs_gpio_write && avs_gpio_address == 3'(k + 2))
          for (int b = 0; b < 4; b++)
            if (avs_gpio_byteenable[b]) tx_word[k][8*b +: 8] <= avs_gpio_writedata[8*b +: 8];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (avs_gpio_address)
      3'd0:    rd_mux = {ID_CODE, NW8, CD8};
      3'd1:    rd_mux = {26'd0, int_sync, done, int_ie, done_ie, auto_en, (state != IDLE)};
      default: for (int k = 0; k < NWORDS; k++)
                 if (avs_gpio_address == 3'(k + 2)) rd_mux = rx_word[k];
    endcase
  end

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset)     avs_gpio_readdata <= '0;
    else if (avs_gpio_read) avs_gpio_readdata <= rd_mux;
  end
endmodule

// File: tb/tb_sio_chain_ctrl.sv
// Scoreboarded bench for sio_chain_ctrl: bus reads and serial frames are checked
// by independent monitors against expectations queued by the stimulus.
module tb_sio_chain_ctrl;
  localparam int NB = 64;

  logic        rsi_MRST_reset = 1'b1;
  logic        csi_MCLK_clk = 1'b0;
  logic [2:0]  avs_gpio_address = '0;
  logic [31:0] avs_gpio_writedata = '0;
  logic [3:0]  avs_gpio_byteenable = '0;
  logic        avs_gpio_write = 1'b0;
  logic        avs_gpio_read = 1'b0;
  logic [31:0] avs_gpio_readdata;
  logic        avs_gpio_waitrequest;
  logic        ins_irq_irq;
  logic        EPL_SCLK, EPL_SDI, EPL_SLE, EPL_SDO;
  logic        EPL_INT = 1'b0;
  logic        sdo_loop = 1'b1;
  logic        sdo_level = 1'b0;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mask_q[$];
  string       name_q[$];
  logic [63:0] frame_q[$];
  logic        rd_pend = 1'b0;
  logic [63:0] cap = '0;
  int          cap_cnt = 0;
  int          low_cnt = 0;
  int          last_gap = 0;
  logic        prev_sclk = 1'b0;
  logic        prev_sle = 1'b0;

  assign EPL_SDO = sdo_loop ? EPL_SDI : sdo_level;

  sio_chain_ctrl #(.NWORDS(2), .CLKDIV(4), .ID_CODE(16'hEA69)) dut (
    .rsi_MRST_reset(rsi_MRST_reset), .csi_MCLK_clk(csi_MCLK_clk),
    .avs_gpio_address(avs_gpio_address), .avs_gpio_writedata(avs_gpio_writedata),
    .avs_gpio_byteenable(avs_gpio_byteenable), .avs_gpio_write(avs_gpio_write),
    .avs_gpio_read(avs_gpio_read), .avs_gpio_readdata(avs_gpio_readdata),
    .avs_gpio_waitrequest(avs_gpio_waitrequest), .ins_irq_irq(ins_irq_irq),
    .EPL_SCLK(EPL_SCLK), .EPL_SDI(EPL_SDI), .EPL_SDO(EPL_SDO),
    .EPL_SLE(EPL_SLE), .EPL_INT(EPL_INT)
  );

  always #5 csi_MCLK_clk = ~csi_MCLK_clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    @(posedge csi_MCLK_clk); #1;
    avs_gpio_address = a; avs_gpio_writedata = d; avs_gpio_byteenable = be; avs_gpio_write = 1'b1;
    @(posedge csi_MCLK_clk); #1;
    avs_gpio_write = 1'b0;
  endtask

  task automatic expectRead(input logic [2:0] a, input logic [31:0] exp, input logic [31:0] mask,
                            input string name);
    @(posedge csi_MCLK_clk); #1;
    avs_gpio_address = a; avs_gpio_read = 1'b1;
    exp_q.push_back(exp); mask_q.push_back(mask); name_q.push_back(name);
    @(posedge csi_MCLK_clk); #1;
    avs_gpio_read = 1'b0;
  endtask

  // Polls BUSY through the bus; an expired budget shows up as a failed busy check.
  task automatic waitIdle(input string name);
    int n;
    logic [31:0] v;
    n = 0;
    repeat (40) @(posedge csi_MCLK_clk);
    do begin
      expectRead(3'd1, 32'd0, 32'd0, "poll");
      @(negedge csi_MCLK_clk);
      v = avs_gpio_readdata;
      n++;
    end while (v[0] && n < 1500);
    checkOutput(name, {63'd0, v[0]}, 64'd0);
  endtask

  task automatic measurePeriod(output int per);
    int n;
    n = 0; do begin @(negedge csi_MCLK_clk); n++; end while (EPL_SCLK !== 1'b0 && n < 50);
    n = 0; do begin @(negedge csi_MCLK_clk); n++; end while (EPL_SCLK !== 1'b1 && n < 50);
    n = 0; do begin @(negedge csi_MCLK_clk); n++; end while (EPL_SCLK !== 1'b0 && n < 50);
    do begin @(negedge csi_MCLK_clk); n++; end while (EPL_SCLK !== 1'b1 && n < 50);
    per = n;
  endtask

  always @(posedge csi_MCLK_clk) rd_pend <= avs_gpio_read;

  always @(negedge csi_MCLK_clk) begin
    logic [31:0] e, m;
    string nm;
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("[TB] FAIL read_unexpected actual=0x%0h expected=none", avs_gpio_readdata);
      end else begin
        e = exp_q.pop_front(); m = mask_q.pop_front(); nm = name_q.pop_front();
        if (m != 32'd0) checkOutput(nm, {32'd0, avs_gpio_readdata & m}, {32'd0, e});
      end
    end
  end

  // Serial frame monitor: SDI captured on each SCLK rise while SLE is high.
  always @(negedge csi_MCLK_clk) begin
    if (rsi_MRST_reset) begin
      cap_cnt = 0; prev_sclk = 1'b0; prev_sle = 1'b0; low_cnt = 0;
    end else begin
      if (EPL_SCLK && !prev_sclk && EPL_SLE) begin
        cap = {cap[62:0], EPL_SDI};
        cap_cnt++;
      end
      if (!EPL_SLE && prev_sle) begin
        if (frame_q.size() == 0) begin
          checks++; failures++;
          $display("[TB] FAIL frame_unexpected actual=0x%0h expected=none", cap);
        end else begin
          checkOutput("frame_data", cap, frame_q.pop_front());
          checkOutput("frame_len", 64'(cap_cnt), 64'(NB));
        end
        cap_cnt = 0;
      end
      if (EPL_SLE && !prev_sle) last_gap = low_cnt;
      if (!EPL_SLE) low_cnt++; else low_cnt = 0;
      prev_sclk = EPL_SCLK;
      prev_sle  = EPL_SLE;
    end
  end

  initial begin
    int per;
    $display("[TB] start");
    repeat (3) @(posedge csi_MCLK_clk);
    #1;
    checkOutput("reset_pins", {60'd0, EPL_SCLK, EPL_SLE, EPL_SDI, ins_irq_irq}, 64'd0);
    checkOutput("reset_readdata", {32'd0, avs_gpio_readdata}, 64'd0);
    @(negedge csi_MCLK_clk); rsi_MRST_reset = 1'b0;

    // Identification, waitrequest and SCLK period
    expectRead(3'd0, 32'hEA690204, 32'hFFFFFFFF, "id_reg");
    checkOutput("waitrequest", {63'd0, avs_gpio_waitrequest}, 64'd0);
    measurePeriod(per);
    checkOutput("sclk_period", 64'(per), 64'd8);

    // Loopback frame, including a byte-enabled TX write
    applyStimulus(3'd2, 32'hA5A50F0F, 4'hF);
    applyStimulus(3'd3, 32'h12FF56FF, 4'hF);
    applyStimulus(3'd3, 32'hAA34BB78, 4'b0101);
    frame_q.push_back(64'hA5A50F0F12345678);
    applyStimulus(3'd1, 32'h1, 4'hF);
    waitIdle("busy_frame1");
    expectRead(3'd1, 32'h10, 32'hFFFFFFFF, "status_done");
    expectRead(3'd2, 32'hA5A50F0F, 32'hFFFFFFFF, "rx0_loop");
    expectRead(3'd3, 32'h12345678, 32'hFFFFFFFF, "rx1_loop");
    applyStimulus(3'd7, 32'hFFFFFFFF, 4'hF);
    expectRead(3'd7, 32'h0, 32'hFFFFFFFF, "addr7_zero");
    expectRead(3'd4, 32'h0, 32'hFFFFFFFF, "addr4_zero");

    // SDO tied high; START while busy is ignored
    applyStimulus(3'd1, 32'h10, 4'hF);
    expectRead(3'd1, 32'h0, 32'hFFFFFFFF, "done_w1c");
    sdo_loop = 1'b0; sdo_level = 1'b1;
    frame_q.push_back(64'hA5A50F0F12345678);
    applyStimulus(3'd1, 32'h1, 4'hF);
    repeat (100) @(posedge csi_MCLK_clk);
    applyStimulus(3'd1, 32'h1, 4'hF);
    expectRead(3'd1, 32'h1, 32'hFFFFFFFF, "status_busy");
    waitIdle("busy_frame2");
    repeat (100) @(posedge csi_MCLK_clk);
    expectRead(3'd1, 32'h10, 32'hFFFFFFFF, "no_second_frame");
    expectRead(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, "rx0_ones");
    expectRead(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, "rx1_ones");

    // Auto mode with a mid-frame TX update, then AUTO cleared
    sdo_loop = 1'b1;
    applyStimulus(3'd1, 32'h10, 4'hF);
    frame_q.push_back(64'hA5A50F0F12345678);
    frame_q.push_back(64'hDEADBEEF12345678);
    applyStimulus(3'd1, 32'h2, 4'hF);
    repeat (100) @(posedge csi_MCLK_clk);
    applyStimulus(3'd2, 32'hDEADBEEF, 4'hF);
    repeat (500) @(posedge csi_MCLK_clk);
    applyStimulus(3'd1, 32'h0, 4'hF);
    waitIdle("busy_auto_end");
    checkOutput("auto_gap", 64'(last_gap), 64'd16);
    expectRead(3'd1, 32'h10, 32'hFFFFFFFF, "status_auto_off");
    expectRead(3'd2, 32'hDEADBEEF, 32'hFFFFFFFF, "rx0_auto");

    // Interrupts: DONE_IE and INT_IE paths
    applyStimulus(3'd1, 32'h14, 4'hF);
    #1 checkOutput("irq_cleared", {63'd0, ins_irq_irq}, 64'd0);
    frame_q.push_back(64'hDEADBEEF12345678);
    applyStimulus(3'd1, 32'h5, 4'hF);
    waitIdle("busy_irq_frame");
    #1 checkOutput("irq_done", {63'd0, ins_irq_irq}, 64'd1);
    expectRead(3'd1, 32'h14, 32'hFFFFFFFF, "status_done_ie");
    applyStimulus(3'd1, 32'h14, 4'hF);
    #1 checkOutput("irq_w1c", {63'd0, ins_irq_irq}, 64'd0);
    applyStimulus(3'd1, 32'h8, 4'hF);
    EPL_INT = 1'b1;
    repeat (3) @(posedge csi_MCLK_clk);
    #1 checkOutput("irq_int", {63'd0, ins_irq_irq}, 64'd1);
    expectRead(3'd1, 32'h28, 32'hFFFFFFFF, "status_int");
    EPL_INT = 1'b0;
    repeat (3) @(posedge csi_MCLK_clk);
    #1 checkOutput("irq_int_low", {63'd0, ins_irq_irq}, 64'd0);

    // Reset in the middle of a frame
    applyStimulus(3'd1, 32'h1, 4'hF);
    repeat (200) @(posedge csi_MCLK_clk);
    @(negedge csi_MCLK_clk);
    checkOutput("sle_midframe", {63'd0, EPL_SLE}, 64'd1);
    #2 rsi_MRST_reset = 1'b1;
    #1 checkOutput("abort_pins", {61'd0, EPL_SCLK, EPL_SLE, EPL_SDI}, 64'd0);
    repeat (2) @(posedge csi_MCLK_clk);
    @(negedge csi_MCLK_clk); rsi_MRST_reset = 1'b0;
    expectRead(3'd1, 32'h0, 32'hFFFFFFFF, "status_after_abort");
    expectRead(3'd2, 32'h0, 32'hFFFFFFFF, "rx0_after_abort");
    expectRead(3'd3, 32'h0, 32'hFFFFFFFF, "rx1_after_abort");

    repeat (5) @(posedge csi_MCLK_clk);
    checkOutput("frames_pending", 64'(frame_q.size()), 64'd0);
    checkOutput("reads_pending", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sio_chain_ctrl.md
Name: sio_chain_ctrl

Overview:
Avalon-MM slave that drives a serial expander (EPL) chain with a generated SCLK, a framing latch (SLE), and full-duplex data (SDI out, SDO in).
- It generalises the fixed 32-bit SIO port: chain length (NWORDS x 32 bits) and SCLK rate are parameters.
- It adds explicit start/busy/done handshake, continuous auto-refresh mode, and an interrupt.
- It sits between the Qsys interconnect and the off-chip expander chain.

Parameters:
NWORDS, 2, number of 32-bit words in the chain (1..4); chain length N = 32*NWORDS.
CLKDIV, 4, MCLK cycles per SCLK half-period (1..255).
ID_CODE, 16'hEA69, identifier returned in register 0 [31:16].

Ports:
rsi_MRST_reset  in  1  asynchronous, active-high reset
csi_MCLK_clk  in  1  system clock; all logic in this domain
avs_gpio_address  in  3  word address
avs_gpio_writedata  in  32  write data
avs_gpio_byteenable  in  4  byte lanes for writes to regs 2..5
avs_gpio_write  in  1  write strobe
avs_gpio_read  in  1  read strobe
avs_gpio_readdata  out  32  registered read data, read latency 1
avs_gpio_waitrequest  out  1  tied 0
ins_irq_irq  out  1  level interrupt
EPL_SCLK  out  1  serial clock, registered
EPL_SDI  out  1  serial data to chain, MSB first
EPL_SDO  in  1  serial data from chain
EPL_SLE  out  1  frame: low = load/latch, high = shifting
EPL_INT  in  1  async interrupt from chain

Behaviour:
Reset (async):
- all registers 0, state IDLE.
- EPL_SCLK=0, EPL_SDI=0, EPL_SLE=0, readdata=0, irq=0.

Register map (read data = value at address, registered next cycle):
- 0 (RO): {ID_CODE, NWORDS[7:0], CLKDIV[7:0]}.
- 1 CTRL/STATUS.
  - Write: bit0 START (pulse, not stored); bit1 AUTO; bit2 DONE_IE; bit3 INT_IE; bit4 DONE clear (W1C).
  - Read: bit0 BUSY, bit1 AUTO, bit2 DONE_IE, bit3 INT_IE, bit4 DONE, bit5 INT_SYNC; all other bits 0.
- 2..1+NWORDS: write = TX word k (byte-enabled); read = RX word k.
- Other addresses: reads 0, writes ignored.
- Word 2 maps to chain bits [N-1:N-32] (shifted out first).

SCLK:
- Free-running divider: toggles every CLKDIV MCLK cycles.
- Rise tick = MCLK cycle in which EPL_SCLK goes 0->1; fall tick = 1->0.
- All state changes occur on fall ticks only.

FSM (BUSY = state != IDLE):
- IDLE: START or AUTO=1 -> LOAD at next fall tick.
- LOAD (1 SCLK period): SLE=0; shreg <= TX words; bitcnt <= 0.
  - At next fall tick -> SHIFT with SLE=1, SDI = shreg[N-1].
- SHIFT:
  - Rise tick: sdo_s <= EPL_SDO.
  - Fall tick: shreg <= {shreg[N-2:0], sdo_s}; SDI <= shreg[N-2]; bitcnt++.
  - After the N-th fall tick -> LATCH; SLE=0, SDI=0.
- LATCH (1 SCLK period): RX words <= shreg; DONE <= 1 at entry.
  - Next fall tick: if AUTO -> LOAD, else -> IDLE.
- Frame length: N+2 SCLK periods = (N+2)*2*CLKDIV MCLK cycles.

Handshake and boundary rules:
- START while BUSY: ignored.
- START and AUTO set in the same write: one start, then continuous operation.
- Clearing AUTO mid-frame: current frame completes, then IDLE.
- TX writes while BUSY update TX immediately; they take effect at the next LOAD (current frame unaffected).
- RX changes only at LATCH entry. A read in the same cycle returns the old value.
- DONE set and W1C clear in the same cycle: set wins.
- EPL_INT: 2-flop synchroniser to INT_SYNC.
- irq = (DONE & DONE_IE) | (INT_SYNC & INT_IE).
- Reset mid-frame: immediate abort; RX and TX cleared; outputs return to reset values.

Test Plan:
1. Reset, read addr 0 (NWORDS=2, CLKDIV=4) -> 0xEA690204 one cycle later; waitrequest always 0; SCLK period 8 MCLK cycles.
2. Write TX0=0xA5A5_0F0F, TX1=0x1234_5678, START; loopback SDO<-SDI.
   - SDI emits 0xA5A50F0F12345678 MSB first over 64 SCLK periods, SLE high for exactly 64 periods.
   - DONE=1 after 66 periods (528 MCLK).
   - RX0/RX1 read back 0xA5A50F0F/0x12345678 (loopback delay aligned by rise-tick sampling).
3. SDO tied 1, START -> RX words 0xFFFFFFFF. START issued during BUSY -> no second frame; BUSY falls after one frame.
4. AUTO=1 -> back-to-back frames, each with one LOAD and one LATCH period at SLE=0.
   - Write TX mid-frame -> new value appears only in the following frame.
   - Clear AUTO -> exactly one more frame completes, then IDLE.
5. DONE_IE=1 -> irq asserts at LATCH; W1C clears it. INT_IE=1, pulse EPL_INT high -> irq within 3 MCLK cycles.
6. Assert reset at bit 20 of a frame -> SLE/SDI/SCLK go 0 asynchronously; after release, BUSY=0 and RX=0.
